// File: rtl/noc_inject_arbiter_pkg.sv
// Shared NoC widths (Noc_parameters.v contents) and injection-arbiter FSM encoding/helpers.
`ifndef NOC_PARAMETERS_V
`define NOC_PARAMETERS_V
`define Noc_Data_Width 32
`endif

package noc_inject_arbiter_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Pointer/index width for n requesters; never narrower than one bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo N.
module noc_rr_arbiter
  import noc_inject_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = ptr_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     pick
);

  logic [PTR_W-1:0] idx;

  // Scan farthest-to-nearest so the candidate closest to ptr wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(ptr) + k) % N);
      if (req[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-atomic round-robin arbiter for N requesters onto one NoC injection port.
// Optional 16-bit tail counter pkt_sent_cnt when NOC_INJ_STATS_EN is defined.
module noc_inject_arbiter
  import noc_inject_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int FLIT_W  = `Noc_Data_Width
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*FLIT_W-1:0] req_flit,
  input  logic [NUM_REQ-1:0]        req_is_header,
  input  logic [NUM_REQ-1:0]        req_is_tail,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [FLIT_W-1:0]         out_flit,
  output logic                      out_is_header,
  output logic                      out_is_tail,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy
`ifdef NOC_INJ_STATS_EN
  ,
  output logic [15:0]               pkt_sent_cnt
`endif
);

  localparam int PTR_W = ptr_w(NUM_REQ);

  logic [0:0]         state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   g_idx;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] pick;
  logic               tail_xfer;

  // Only packet headers may start a new ownership period.
  assign eligible = req_valid & req_is_header;

  noc_rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req  (eligible),
    .ptr  (rr_ptr),
    .pick (pick)
  );

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) g_idx = PTR_W'(i);
    end
  end

  always_comb begin
    out_valid     = 1'b0;
    out_flit      = '0;
    out_is_header = 1'b0;
    out_is_tail   = 1'b0;
    req_ready     = '0;
    if (state == ST_BUSY) begin
      out_valid     = req_valid[g_idx];
      out_flit      = req_flit[g_idx*FLIT_W +: FLIT_W];
      out_is_header = req_is_header[g_idx];
      out_is_tail   = req_is_tail[g_idx];
      req_ready     = grant & {NUM_REQ{out_ready}};
    end
  end

  assign tail_xfer = out_valid & out_ready & out_is_tail;
  assign busy      = (state == ST_BUSY);

  // No arbitration in the tail cycle: IDLE always lasts at least one cycle.
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      state  <= ST_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else if (state == ST_IDLE) begin
      if (|pick) begin
        grant <= pick;
        state <= ST_BUSY;
      end
    end else if (tail_xfer) begin
      state  <= ST_IDLE;
      grant  <= '0;
      rr_ptr <= (g_idx == PTR_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
    end
  end

`ifdef NOC_INJ_STATS_EN
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      pkt_sent_cnt <= '0;
    end else if (tail_xfer) begin
      pkt_sent_cnt <= pkt_sent_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Scoreboard bench for noc_inject_arbiter: directed packets, expected flits queued in grant order.
module tb_noc_inject_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic             noc_clk = 1'b0;
  logic             noc_rst;
  logic [N-1:0]     req_valid, req_ready, req_is_header, req_is_tail, grant;
  logic [N*W-1:0]   req_flit;
  logic             out_valid, out_ready, out_is_header, out_is_tail, busy;
  logic [W-1:0]     out_flit;
`ifdef NOC_INJ_STATS_EN
  logic [15:0]      pkt_sent_cnt;
  logic [15:0]      cnt_before;
`endif

  typedef struct packed {
    logic         hdr;
    logic         tail;
    logic [W-1:0] flit;
  } flit_t;

  typedef struct packed {
    logic [N-1:0] gnt;
    logic         hdr;
    logic         tail;
    logic [W-1:0] flit;
  } exp_t;

  flit_t    src[N][$];
  exp_t     exp_q[$];
  int       errors = 0;
  int       checks = 0;
  logic [N-1:0] acc = '0;
  bit       drv_en = 1'b0;
  bit       toggle_rdy = 1'b0;
  bit       prev_tail = 1'b0;

  always #5 noc_clk = ~noc_clk;

  noc_inject_arbiter #(.NUM_REQ(N), .FLIT_W(W)) dut (
    .noc_clk       (noc_clk),
    .noc_rst       (noc_rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_flit      (req_flit),
    .req_is_header (req_is_header),
    .req_is_tail   (req_is_tail),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_flit      (out_flit),
    .out_is_header (out_is_header),
    .out_is_tail   (out_is_tail),
    .grant         (grant),
    .busy          (busy)
`ifdef NOC_INJ_STATS_EN
    ,
    .pkt_sent_cnt  (pkt_sent_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic flit_t mk(input int r, input int p, input int i, input bit h, input bit t);
    flit_t f;
    f.hdr  = h;
    f.tail = t;
    f.flit = {8'(r), 8'(p), 16'(i)};
    return f;
  endfunction

  // Queue a packet on requester r and its expected output flits, in expected grant order.
  task automatic send_pkt(input int r, input int p, input int len);
    flit_t f;
    exp_t  e;
    for (int i = 0; i < len; i++) begin
      f = mk(r, p, i, (i == 0), (i == len - 1));
      src[r].push_back(f);
      e.gnt    = '0;
      e.gnt[r] = 1'b1;
      e.hdr    = f.hdr;
      e.tail   = f.tail;
      e.flit   = f.flit;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n = 0;
    while (exp_q.size() > 0 && n < max_cyc) begin
      @(posedge noc_clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: %0d flits outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
      for (int i = 0; i < N; i++) src[i].delete();
    end
    repeat (2) @(posedge noc_clk);
    #3;
  endtask

  // Driver: retire accepted flits, present queue heads, shape out_ready.
  initial begin
    forever begin
      @(posedge noc_clk);
      #1;
      if (drv_en) begin
        for (int i = 0; i < N; i++) begin
          if (acc[i] && src[i].size() > 0) void'(src[i].pop_front());
          if (src[i].size() > 0) begin
            req_valid[i]       = 1'b1;
            req_is_header[i]   = src[i][0].hdr;
            req_is_tail[i]     = src[i][0].tail;
            req_flit[i*W +: W] = src[i][0].flit;
          end else begin
            req_valid[i]       = 1'b0;
            req_is_header[i]   = 1'b0;
            req_is_tail[i]     = 1'b0;
            req_flit[i*W +: W] = '0;
          end
        end
        out_ready = toggle_rdy ? ~out_ready : 1'b1;
      end
    end
  end

  // Monitor: sampled mid-cycle, pops the scoreboard on every output transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge noc_clk);
      if (noc_rst) begin
        acc       = '0;
        prev_tail = 1'b0;
      end else begin
        if (prev_tail) check("gap_after_tail", {62'd0, out_valid, busy}, 64'd0);
        if (!busy) check("idle_outputs", {req_ready, out_valid}, 64'd0);
        else if (exp_q.size() > 0)
          check("ready_mirror", req_ready, exp_q[0].gnt & {N{out_ready}});
        acc = req_valid & req_ready;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_xfer: flit %h delivered, none expected", out_flit);
          end else begin
            e = exp_q.pop_front();
            check("xfer", {grant, out_is_header, out_is_tail, out_flit}, e);
            check("src_accept", acc, e.gnt);
          end
          prev_tail = out_is_tail;
        end else begin
          prev_tail = 1'b0;
        end
      end
    end
  end

  initial begin
    int n;
    noc_rst       = 1'b1;
    req_valid     = '1;
    req_is_header = '1;
    req_is_tail   = '0;
    req_flit      = '0;
    out_ready     = 1'b1;

    // Reset held with all requesters asking.
    repeat (4) begin
      @(posedge noc_clk);
      #3;
      check("rst_grant", grant, 64'd0);
      check("rst_ready", req_ready, 64'd0);
      check("rst_out", {62'd0, out_valid, busy}, 64'd0);
    end
    req_valid     = '0;
    req_is_header = '0;
    drv_en        = 1'b1;
    noc_rst       = 1'b0;

    // Fairness: order 0,1,2,3,0,1,2,3.
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < N; r++) send_pkt(r, p, 3);
    wait_drain("fairness", 300);

    // Backpressure: 12 flits from requester 2, out_ready alternating.
    toggle_rdy = 1'b1;
    out_ready  = 1'b0;
    send_pkt(2, 0, 12);
    wait_drain("backpressure", 300);
    toggle_rdy = 1'b0;

    // Non-header flit on requester 1 must stall; requester 3 header arrives a cycle later.
    src[1].push_back(mk(1, 9, 0, 1'b0, 1'b0));
    @(posedge noc_clk);
    #3;
    send_pkt(3, 0, 2);
    @(posedge noc_clk);
    #3;
    @(posedge noc_clk);
    #3;
    check("hdr_grant_latency", {grant, out_valid, out_is_header}, {58'd0, 4'b1000, 1'b1, 1'b1});
    wait_drain("nonheader_guard", 100);
    check("nonhdr_stalled", {62'd0, req_valid[1], req_ready[1]}, 64'd2);
    src[1].delete();
    @(posedge noc_clk);
    #3;

    // Single-flit packet from requester 0, then rr_ptr=1 means 1 beats 0.
`ifdef NOC_INJ_STATS_EN
    cnt_before = pkt_sent_cnt;
`endif
    send_pkt(0, 0, 1);
    wait_drain("single_flit", 50);
    check("single_idle", {63'd0, busy}, 64'd0);
`ifdef NOC_INJ_STATS_EN
    check("pkt_sent_cnt", pkt_sent_cnt, cnt_before + 16'd1);
`endif
    send_pkt(1, 0, 2);
    send_pkt(0, 1, 2);
    wait_drain("rr_after_single", 100);

    // Mid-packet reset on requester 3 at flit 5.
    send_pkt(3, 1, 8);
    n = 0;
    while (!(out_valid && out_flit == mk(3, 1, 4, 1'b0, 1'b0).flit) && n < 100) begin
      @(posedge noc_clk);
      #3;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL mid_rst_wait: flit 5 of requester 3 never seen, expected within 100 cycles");
    end
    noc_rst = 1'b1;
    #1;
    check("mid_rst_out", {out_valid, busy, out_flit}, 64'd0);
    check("mid_rst_grant", {grant, req_ready}, 64'd0);
    exp_q.delete();
    for (int i = 0; i < N; i++) src[i].delete();
    repeat (2) @(posedge noc_clk);
    #3;
    noc_rst = 1'b0;
    send_pkt(0, 2, 2);
    send_pkt(3, 2, 2);
    wait_drain("post_reset_rr", 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
